counter_sequence_checker: RTL and testbench

COUNTER_SEQUENCE_CHECKER -- requirements
Module: counter_sequence_checker

---
 rtl/counter_pkg.sv | 23 ++
 rtl/counter_sequence_checker_sat_counter16.sv | 37 +++
 rtl/counter_sequence_checker.sv | 145 ++++++++++++++
 tb/tb_counter_sequence_checker.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the counter sequence checker.
//   - checker state encoding
//   - default last count value before wrap
//   - width constants and the next-count helper
package counter_pkg;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned RUN_W = 4;

  localparam logic [7:0] DEFAULT_MAX_VALUE = 8'hA7;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_LOCKING = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  // Value that should follow x on a counter that wraps after max_v.
  function automatic logic [7:0] next_val(input logic [7:0] x, input logic [7:0] max_v);
    return (x == max_v) ? 8'h00 : 8'(x + 8'd1);
  endfunction

endpackage

// File: rtl/counter_sequence_checker_sat_counter16.sv
// sat_counter16: 16-bit saturating incrementer.
// Ports:
//   clock  - rising-edge clock
//   reset  - synchronous active-high clear
//   en     - increment request (ignored once at all-ones)
//   count  - registered count value
module sat_counter16
  import counter_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  output logic [15:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Hold at all-ones instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (en && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/counter_sequence_checker.sv
// counter_sequence_checker: tracks a free-running wrapping counter observed on
// sample, locks after LOCK_LEN consecutive in-sequence samples and flags
// out-of-sequence samples seen while locked.
// Ports:
//   clock, reset  - rising-edge clock, synchronous active-high reset
//   sample_valid  - qualifies sample this cycle
//   sample        - observed counter value
//   locked        - high while in LOCKED state
//   error_pulse   - one-cycle pulse after a mismatch while locked
//   error_count   - saturating number of errors since reset
//   expected      - next value the checker expects
//   wrap_count    - saturating count of locked MAX_VALUE->0 wraps
//                   (only when COUNTER_SEQUENCE_CHECKER_WRAP_COUNT_EN is defined)
module counter_sequence_checker
  import counter_pkg::*;
#(
  parameter logic [7:0]  MAX_VALUE = DEFAULT_MAX_VALUE,
  parameter int unsigned LOCK_LEN  = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sample_valid,
  input  logic [7:0]  sample,
  output logic        locked,
  output logic        error_pulse,
  output logic [15:0] error_count,
`ifdef COUNTER_SEQUENCE_CHECKER_WRAP_COUNT_EN
  output logic [15:0] wrap_count,
`endif
  output logic [7:0]  expected
);

  state_e           state_q, state_d;
  logic [7:0]       expected_q, expected_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             locked_q, locked_d;
  logic             error_pulse_q, error_pulse_d;

  logic             in_range_c;
  logic             match_c;
  logic [RUN_W-1:0] run_inc_c;
  logic             err_inc_c;

  // Out-of-range samples can never match since expected_q is always in range.
  assign in_range_c = (sample <= MAX_VALUE);
  assign match_c    = in_range_c && (sample == expected_q);
  assign run_inc_c  = run_q + RUN_W'(1);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_SEARCH;
      expected_q    <= 8'h00;
      run_q         <= '0;
      locked_q      <= 1'b0;
      error_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      expected_q    <= expected_d;
      run_q         <= run_d;
      locked_q      <= locked_d;
      error_pulse_q <= error_pulse_d;
    end
  end

  // Next state, expected value and run length.
  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    run_d      = run_q;
    if (sample_valid) begin
      case (state_q)
        ST_SEARCH: begin
          if (in_range_c) begin
            expected_d = next_val(sample, MAX_VALUE);
            run_d      = RUN_W'(1);
            state_d    = ST_LOCKING;
          end
        end
        ST_LOCKING: begin
          if (match_c) begin
            expected_d = next_val(sample, MAX_VALUE);
            run_d      = run_inc_c;
            if (run_inc_c == RUN_W'(LOCK_LEN)) begin
              state_d = ST_LOCKED;
            end
          end else if (in_range_c) begin
            // Restart the run on the new value.
            expected_d = next_val(sample, MAX_VALUE);
            run_d      = RUN_W'(1);
          end else begin
            state_d = ST_SEARCH;
          end
        end
        ST_LOCKED: begin
          if (match_c) begin
            expected_d = next_val(sample, MAX_VALUE);
          end else if (in_range_c) begin
            expected_d = next_val(sample, MAX_VALUE);
            run_d      = RUN_W'(1);
            state_d    = ST_LOCKING;
          end else begin
            state_d = ST_SEARCH;
          end
        end
        default: begin
          state_d = ST_SEARCH;
        end
      endcase
    end
  end

  // Registered-output next values.
  always_comb begin
    locked_d      = (state_d == ST_LOCKED);
    error_pulse_d = sample_valid && (state_q == ST_LOCKED) && !match_c;
    err_inc_c     = error_pulse_d;
  end

  sat_counter16 u_error_count (
    .clock (clock),
    .reset (reset),
    .en    (err_inc_c),
    .count (error_count)
  );

`ifdef COUNTER_SEQUENCE_CHECKER_WRAP_COUNT_EN
  logic wrap_inc_c;

  // A locked match on 0 can only follow MAX_VALUE.
  assign wrap_inc_c = sample_valid && (state_q == ST_LOCKED) && match_c && (sample == 8'h00);

  sat_counter16 u_wrap_count (
    .clock (clock),
    .reset (reset),
    .en    (wrap_inc_c),
    .count (wrap_count)
  );
`endif

  assign locked      = locked_q;
  assign error_pulse = error_pulse_q;
  assign expected    = expected_q;

endmodule

// File: tb/tb_counter_sequence_checker.sv
// Directed self-checking bench for counter_sequence_checker (default
// parameters) plus a saturation run on sat_counter16.
module tb_counter_sequence_checker;

  logic        clock = 1'b0;
  logic        reset;
  logic        sample_valid;
  logic [7:0]  sample;
  logic        locked;
  logic        error_pulse;
  logic [15:0] error_count;
  logic [7:0]  expected;
`ifdef COUNTER_SEQUENCE_CHECKER_WRAP_COUNT_EN
  logic [15:0] wrap_count;
`endif

  logic        sat_reset;
  logic        sat_en;
  logic [15:0] sat_count;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  counter_sequence_checker dut (
    .clock        (clock),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample       (sample),
    .locked       (locked),
    .error_pulse  (error_pulse),
    .error_count  (error_count),
`ifdef COUNTER_SEQUENCE_CHECKER_WRAP_COUNT_EN
    .wrap_count   (wrap_count),
`endif
    .expected     (expected)
  );

  sat_counter16 u_sat (
    .clock (clock),
    .reset (sat_reset),
    .en    (sat_en),
    .count (sat_count)
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Apply one sample for one clock, then settle past the edge.
  task automatic drive(input logic v, input logic [7:0] s);
    sample_valid = v;
    sample       = s;
    @(posedge clock);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic lk, input logic ep,
                            input logic [15:0] ec, input logic [7:0] ex);
    check_eq({tag, ".locked"},      16'(locked),      16'(lk));
    check_eq({tag, ".error_pulse"}, 16'(error_pulse), 16'(ep));
    check_eq({tag, ".error_count"}, error_count,      ec);
    check_eq({tag, ".expected"},    16'(expected),    16'(ex));
  endtask

  initial begin
    reset        = 1'b1;
    sample_valid = 1'b0;
    sample       = 8'h00;
    sat_reset    = 1'b1;
    sat_en       = 1'b0;

    drive(1'b0, 8'h00);
    drive(1'b0, 8'h00);
    check_outs("reset", 1'b0, 1'b0, 16'h0000, 8'h00);
`ifdef COUNTER_SEQUENCE_CHECKER_WRAP_COUNT_EN
    check_eq("reset.wrap_count", wrap_count, 16'h0000);
`endif
    reset = 1'b0;

    // Lock on 10..13.
    drive(1'b1, 8'h10);
    drive(1'b1, 8'h11);
    drive(1'b1, 8'h12);
    check_outs("lock_run3", 1'b0, 1'b0, 16'h0000, 8'h13);
    drive(1'b1, 8'h13);
    check_outs("lock", 1'b1, 1'b0, 16'h0000, 8'h14);

    // Idle cycle changes nothing.
    drive(1'b0, 8'h55);
    check_outs("idle", 1'b1, 1'b0, 16'h0000, 8'h14);

    for (int v = 8'h14; v <= 8'h1F; v++) drive(1'b1, 8'(v));
    check_outs("at20", 1'b1, 1'b0, 16'h0000, 8'h20);

    // Locked mismatch then relock.
    drive(1'b1, 8'h25);
    check_outs("err25", 1'b0, 1'b1, 16'h0001, 8'h26);
    drive(1'b1, 8'h26);
    check_outs("after26", 1'b0, 1'b0, 16'h0001, 8'h27);
    drive(1'b1, 8'h27);
    drive(1'b1, 8'h28);
    check_outs("relock28", 1'b1, 1'b0, 16'h0001, 8'h29);

    // Out-of-range while locked, then in SEARCH.
    drive(1'b1, 8'hB0);
    check_outs("b0_locked", 1'b0, 1'b1, 16'h0002, 8'h29);
    drive(1'b1, 8'hB0);
    check_outs("b0_search", 1'b0, 1'b0, 16'h0002, 8'h29);
    drive(1'b1, 8'h40);
    drive(1'b1, 8'h41);
    drive(1'b1, 8'h42);
    check_outs("s_run3", 1'b0, 1'b0, 16'h0002, 8'h43);
    drive(1'b1, 8'h43);
    check_outs("s_lock", 1'b1, 1'b0, 16'h0002, 8'h44);

    // Wrap while locked.
    for (int v = 8'h44; v <= 8'hA5; v++) drive(1'b1, 8'(v));
    drive(1'b1, 8'hA6);
    check_outs("wrapA6", 1'b1, 1'b0, 16'h0002, 8'hA7);
    drive(1'b1, 8'hA7);
    check_outs("wrapA7", 1'b1, 1'b0, 16'h0002, 8'h00);
    drive(1'b1, 8'h00);
    check_outs("wrap00", 1'b1, 1'b0, 16'h0002, 8'h01);
    drive(1'b1, 8'h01);
    check_outs("wrap01", 1'b1, 1'b0, 16'h0002, 8'h02);
`ifdef COUNTER_SEQUENCE_CHECKER_WRAP_COUNT_EN
    check_eq("wrap_count1", wrap_count, 16'h0001);
`endif

    // Mismatch in LOCKING restarts the run without an error.
    drive(1'b1, 8'h05);
    check_outs("err05", 1'b0, 1'b1, 16'h0003, 8'h06);
    drive(1'b1, 8'h09);
    check_outs("locking09", 1'b0, 1'b0, 16'h0003, 8'h0A);
    drive(1'b1, 8'h0A);
    drive(1'b1, 8'h0B);
    check_outs("run3_0B", 1'b0, 1'b0, 16'h0003, 8'h0C);
    drive(1'b1, 8'h0C);
    check_outs("lock0C", 1'b1, 1'b0, 16'h0003, 8'h0D);

    // 00 after a non-MAX value is a mismatch.
    drive(1'b1, 8'h00);
    check_outs("bad00", 1'b0, 1'b1, 16'h0004, 8'h01);
    drive(1'b1, 8'h01);
    drive(1'b1, 8'h02);
    drive(1'b1, 8'h03);
    check_outs("lock03", 1'b1, 1'b0, 16'h0004, 8'h04);
`ifdef COUNTER_SEQUENCE_CHECKER_WRAP_COUNT_EN
    check_eq("wrap_count_nochg", wrap_count, 16'h0001);
`endif

    // Reset beats a mismatching valid sample.
    reset = 1'b1;
    drive(1'b1, 8'h77);
    check_outs("rst_mid", 1'b0, 1'b0, 16'h0000, 8'h00);
`ifdef COUNTER_SEQUENCE_CHECKER_WRAP_COUNT_EN
    check_eq("rst_mid.wrap_count", wrap_count, 16'h0000);
`endif
    reset = 1'b0;

    // Range boundary: A8 rejected, A7 accepted and wraps to 00.
    drive(1'b1, 8'hA8);
    check_outs("a8_search", 1'b0, 1'b0, 16'h0000, 8'h00);
    drive(1'b1, 8'hA7);
    check_outs("a7_locking", 1'b0, 1'b0, 16'h0000, 8'h00);
    drive(1'b1, 8'h00);
    drive(1'b1, 8'h01);
    drive(1'b1, 8'h02);
    check_outs("lock_from_a7", 1'b1, 1'b0, 16'h0000, 8'h03);
    drive(1'b0, 8'h00);

    // Saturation of the shared incrementer.
    sat_reset = 1'b0;
    sat_en    = 1'b1;
    repeat (65534) @(posedge clock);
    #1;
    check_eq("sat_fffe", sat_count, 16'hFFFE);
    @(posedge clock);
    #1;
    check_eq("sat_ffff", sat_count, 16'hFFFF);
    repeat (3) @(posedge clock);
    #1;
    check_eq("sat_hold", sat_count, 16'hFFFF);
    sat_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
